// File: rtl/store_write_buffer_if.sv
// rtl/store_write_buffer_if.sv - core store/load and memory drain signals of the store write buffer
interface store_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
);
  logic                     MemWrite;
  logic                     MemRead;
  logic [WIDTH-1:0]         DataAdr;
  logic [WIDTH-1:0]         WriteData;
  logic                     Stall;
  logic                     LoadHit;
  logic [WIDTH-1:0]         LoadData;
  logic                     MemValid;
  logic [WIDTH-1:0]         MemAdr;
  logic [WIDTH-1:0]         MemWData;
  logic                     MemReady;
  logic [$clog2(DEPTH):0]   Count;
  logic                     Empty;

  modport master (
    output MemWrite, MemRead, DataAdr, WriteData, MemReady,
    input  Stall, LoadHit, LoadData, MemValid, MemAdr, MemWData, Count, Empty
  );

  modport slave (
    input  MemWrite, MemRead, DataAdr, WriteData, MemReady,
    output Stall, LoadHit, LoadData, MemValid, MemAdr, MemWData, Count, Empty
  );
endinterface

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - in-order store FIFO between core and data memory with load forwarding
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 reset,
  store_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-3:0] adr_q  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             full, empty, push, pop;
  logic             fwd_hit;
  logic [WIDTH-1:0] fwd_data;
  logic [PW-1:0]    fwd_idx;
  logic             unused_adr_lsb;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = bus.MemWrite & ~full;
  assign pop   = ~empty & bus.MemReady;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; validity is defined purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[wr_ptr_q]  <= bus.DataAdr[WIDTH-1:2];
      data_q[wr_ptr_q] <= bus.WriteData;
    end
  end

  // Walk entries oldest to youngest so the last match is the newest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (adr_q[fwd_idx] == bus.DataAdr[WIDTH-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign bus.LoadHit  = bus.MemRead & fwd_hit;
  assign bus.LoadData = bus.LoadHit ? fwd_data : '0;
  assign bus.Stall    = bus.MemWrite & full;
  assign bus.MemValid = ~empty;
  assign bus.Empty    = empty;
  assign bus.Count    = count_q;
  assign bus.MemAdr   = empty ? '0 : {adr_q[rd_ptr_q], 2'b00};
  assign bus.MemWData = empty ? '0 : data_q[rd_ptr_q];

  assign unused_adr_lsb = ^bus.DataAdr[1:0];
endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- FIFO write buffer between the single-cycle core's data-memory port and a slower data memory with a valid/ready handshake.
- Accepts core stores (MemWrite/DataAdr/WriteData) in one cycle and drains them to memory in program order.
- Forwards buffered store data to core loads so that reads of buffered addresses return the newest value.
- Raises Stall when a store cannot be accepted.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, at least 2.
- WIDTH, 32, data and address width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- MemWrite  in  1  core store request this cycle.
- MemRead  in  1  core load request this cycle.
- DataAdr  in  WIDTH  core byte address; bits [1:0] ignored (word aligned).
- WriteData  in  WIDTH  core store data.
- Stall  out  1  store not accepted this cycle; core must hold the store.
- LoadHit  out  1  MemRead address matches a buffered entry.
- LoadData  out  WIDTH  forwarded data from the youngest matching entry.
- MemValid  out  1  head entry presented to memory.
- MemAdr  out  WIDTH  head entry address, word aligned, bits [1:0] = 0.
- MemWData  out  WIDTH  head entry data.
- MemReady  in  1  memory accepts the head entry this cycle.
- Count  out  $clog2(DEPTH)+1  number of valid entries.
- Empty  out  1  Count == 0.

Behaviour:
- State:
  - DEPTH x {addr[WIDTH-1:2], data} storage.
  - Write pointer and read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Count register.
- Reset (synchronous, sampled on the clk rising edge):
  - Pointers and Count go to 0.
  - Outputs the cycle after reset: MemValid=0, Empty=1, Count=0, Stall=0, LoadHit=0.
  - LoadData, MemAdr and MemWData are 0 when invalid. Entry storage is not cleared.
- Reset mid-operation: all buffered entries are discarded. An entry presented with MemValid=1 in the reset cycle counts as not delivered, even if MemReady=1.
- Full: Count == DEPTH.
- Push:
  - Condition: MemWrite & ~full, where full is taken from the registered Count at the start of the cycle.
  - Effect: writes {DataAdr[WIDTH-1:2], WriteData} at the write pointer, then increments the write pointer.
  - Latency: 1 cycle; a stored entry is visible to forwarding and the head on the next cycle.
- Stall:
  - Stall = MemWrite & full, combinational.
  - A full buffer stalls even if MemReady=1 in the same cycle; there is no same-cycle bypass of a freed slot.
- Drain:
  - MemValid = ~Empty, combinational from registered state.
  - MemAdr and MemWData come from the head entry.
  - Pop on MemValid & MemReady; the read pointer increments.
  - The head must stay stable while MemValid=1 & MemReady=0.
- Simultaneous push and pop: Count is unchanged and both pointers advance.
- Count rules:
  - Count +1 on push only, -1 on pop only.
  - Never exceeds DEPTH; never underflows, because pop requires MemValid.
- Forwarding:
  - Fully combinational.
  - Compare DataAdr[WIDTH-1:2] against every valid entry.
  - LoadHit = MemRead & (any match).
  - LoadData = data of the youngest matching entry (closest to the write pointer); 0 when LoadHit=0.
  - An entry popped in the current cycle still participates in forwarding that cycle.
  - A store pushed in the current cycle does not forward until the next cycle.
- Ordering: entries leave strictly in program order. There is no coalescing; repeated stores to one address each occupy an entry.
- Wrap-around: pointers wrap modulo DEPTH; full and empty are distinguished by Count, not by pointer equality.
- MemWrite & MemRead asserted together is not a legal core request. The buffer handles both independently; no checking is required.

Test Plan:
- Reset, then idle → Empty=1, Count=0, MemValid=0, Stall=0 on the cycle after reset deasserts.
- Single store, DataAdr=0x64, WriteData=0x19, MemReady=0 → next cycle: Count=1, MemValid=1, MemAdr=0x64, MemWData=0x19. Raise MemReady for 1 cycle → Count=0 next cycle.
- Four stores to 0x60, 0x64, 0x68, 0x6C with MemReady=0, then a fifth store → Stall=1 on the fifth with Count=4; the fifth is not enqueued. Drain 4 with MemReady=1 → addresses emitted in order 0x60, 0x64, 0x68, 0x6C.
- Stores 0x64←0x7 then 0x64←0x19, then a load of 0x66 with MemReady=0 → LoadHit=1, LoadData=0x19 (youngest wins; low bits ignored). Load of 0x70 → LoadHit=0, LoadData=0.
- Count=2 with push and pop in the same cycle → Count stays 2. Run 10 pushes and pops alternating across pointer wrap → FIFO order preserved and Count never exceeds 4.
- Count=3 with MemValid=1, MemReady=1 and reset=1 in the same cycle → next cycle Count=0, MemValid=0. The entry is not counted as delivered; a checker must see no further pops.
